// File: rtl/iomem_gpio_bank.sv
// WIDTH-pin GPIO bank for the picosoc iomem bus: output/direction registers, synchronised inputs,
// edge-triggered interrupts. Optional input debounce is enabled by defining GPIO_DEBOUNCE_EN.
module iomem_gpio_bank #(
   parameter int               WIDTH           = 8,
   parameter logic [7:0]       BASE_ADDR       = 8'h03,
   parameter logic [WIDTH-1:0] INVERT_IN       = '0,
   parameter int               DEBOUNCE_CYCLES = 16000
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             iomem_valid,
   output logic             iomem_ready,
   input  logic [3:0]       iomem_wstrb,
   input  logic [31:0]      iomem_addr,
   input  logic [31:0]      iomem_wdata,
   output logic [31:0]      iomem_rdata,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   localparam logic [7:0] OFF_OUT  = 8'h00;
   localparam logic [7:0] OFF_IN   = 8'h04;
   localparam logic [7:0] OFF_DIR  = 8'h08;
   localparam logic [7:0] OFF_MASK = 8'h0C;
   localparam logic [7:0] OFF_STAT = 8'h10;
   localparam logic [7:0] OFF_ESEL = 8'h14;

   logic             sel;
   logic             wr_en;
   logic [7:0]       off;
   logic [31:0]      wmask;
   logic [31:0]      rd_val;
   logic [WIDTH-1:0] mask_r;
   logic [WIDTH-1:0] status_r;
   logic [WIDTH-1:0] esel_r;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] in_s;
   logic [WIDTH-1:0] in_d;
   logic [WIDTH-1:0] in_p;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_det;
   logic             primed;
   logic [1:0]       prime_cnt;
   logic             unused_addr;

   assign unused_addr = ^iomem_addr[23:8];

   assign sel   = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
   assign wr_en = sel && (iomem_wstrb != 4'b0000);
   assign off   = iomem_addr[7:0];
   assign wmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

   function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                              input logic [31:0]      wd,
                                              input logic [31:0]      m);
      logic [31:0] r;
      r = (32'(old) & ~m) | (wd & m);
      return r[WIDTH-1:0];
   endfunction

   assign w1c = (wr_en && off == OFF_STAT) ? WIDTH'(iomem_wdata & wmask) : '0;

   always_comb begin
      rd_val = '0;
      case (off)
         OFF_OUT:  rd_val = 32'(gpio_out);
         OFF_IN:   rd_val = 32'(in_d);
         OFF_DIR:  rd_val = 32'(gpio_oe);
         OFF_MASK: rd_val = 32'(mask_r);
         OFF_STAT: rd_val = 32'(status_r);
         OFF_ESEL: rd_val = 32'(esel_r);
         default:  rd_val = '0;
      endcase
   end

   // Input path: two-flop synchroniser, polarity fix, optional debounce, one-cycle delay for edges.
   assign in_s = sync2 ^ INVERT_IN;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1     <= '0;
         sync2     <= '0;
         in_p      <= '0;
         primed    <= 1'b0;
         prime_cnt <= 2'd0;
      end else begin
         sync1 <= gpio_in;
         sync2 <= sync1;
         in_p  <= in_d;
         if (!primed) begin
            prime_cnt <= prime_cnt + 2'd1;
            primed    <= (prime_cnt == 2'd2);
         end
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [PW-1:0]    presc;
   logic             tick;
   logic [WIDTH-1:0] smp;
   logic [WIDTH-1:0] agree;

   assign tick  = (presc == PW'(DEBOUNCE_CYCLES - 1));
   assign agree = ~(in_s ^ smp);

   // A bit moves only when two consecutive tick samples agree.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         presc <= '0;
         smp   <= '0;
         in_d  <= '0;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         if (tick) begin
            smp  <= in_s;
            in_d <= (in_d & ~agree) | (in_s & agree);
         end
      end
   end
`else
   assign in_d = in_s;
`endif

   assign rise     = in_d & ~in_p;
   assign fall     = ~in_d & in_p;
   assign edge_det = primed ? ((esel_r & rise) | (~esel_r & fall)) : '0;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
         gpio_out    <= '0;
         gpio_oe     <= '0;
         mask_r      <= '0;
         status_r    <= '0;
         esel_r      <= '0;
         irq         <= 1'b0;
      end else begin
         iomem_ready <= sel;
         iomem_rdata <= sel ? rd_val : 32'h0;
         if (wr_en) begin
            case (off)
               OFF_OUT:  gpio_out <= merge(gpio_out, iomem_wdata, wmask);
               OFF_DIR:  gpio_oe  <= merge(gpio_oe, iomem_wdata, wmask);
               OFF_MASK: mask_r   <= merge(mask_r, iomem_wdata, wmask);
               OFF_ESEL: esel_r   <= merge(esel_r, iomem_wdata, wmask);
               default:  ;
            endcase
         end
         // A new edge wins over a simultaneous write-1-to-clear of the same bit.
         status_r <= (status_r & ~w1c) | edge_det;
         irq      <= |(status_r & mask_r);
      end
   end

endmodule

// File: tb/tb_iomem_gpio_bank.sv
// Self-checking bench for iomem_gpio_bank: directed vector table, corner-case sequences,
// and randomized bus/pin traffic against a register-level reference model.
module tb_iomem_gpio_bank;

   localparam logic [7:0] INV = 8'h0F;
`ifdef GPIO_DEBOUNCE_EN
   localparam int SETTLE = 14;
`else
   localparam int SETTLE = 5;
`endif

   logic        clk;
   logic        resetn;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;
   logic [7:0]  gpio_oe;
   logic        irq;

   iomem_gpio_bank #(
      .WIDTH(8),
      .BASE_ADDR(8'h03),
      .INVERT_IN(INV),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .iomem_valid(iomem_valid),
      .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb),
      .iomem_addr(iomem_addr),
      .iomem_wdata(iomem_wdata),
      .iomem_rdata(iomem_rdata),
      .gpio_in(gpio_in),
      .gpio_out(gpio_out),
      .gpio_oe(gpio_oe),
      .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_chk = 0;
   int n_fail = 0;

   // Reference model state: register contents and the current logical pin value.
   bit [7:0] m_out, m_dir, m_mask, m_stat, m_esel, m_pin;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic bit [7:0] lane_bits(input bit [31:0] v, input bit [3:0] st);
      bit [31:0] bm;
      bm = 0;
      for (int b = 0; b < 4; b++)
         if (st[b]) bm |= 32'hFF << (8 * b);
      return 8'((v & bm) & 32'hFF);
   endfunction

   task automatic m_write(input bit [7:0] off, input bit [31:0] wd, input bit [3:0] st);
      bit [7:0] v, k;
      v = lane_bits(wd, st);
      k = lane_bits(32'hFFFF_FFFF, st);
      case (off)
         8'h00: m_out  = (m_out  & ~k) | v;
         8'h08: m_dir  = (m_dir  & ~k) | v;
         8'h0C: m_mask = (m_mask & ~k) | v;
         8'h10: m_stat = m_stat & ~v;
         8'h14: m_esel = (m_esel & ~k) | v;
         default: ;
      endcase
   endtask

   function automatic bit [31:0] m_read(input bit [7:0] off);
      case (off)
         8'h00: return {24'h0, m_out};
         8'h04: return {24'h0, m_pin ^ INV};
         8'h08: return {24'h0, m_dir};
         8'h0C: return {24'h0, m_mask};
         8'h10: return {24'h0, m_stat};
         8'h14: return {24'h0, m_esel};
         default: return 32'h0;
      endcase
   endfunction

   // A settled pin change raises status for every logical bit that moved in the selected direction.
   task automatic m_change(input bit [7:0] nv);
      bit [7:0] d, nl;
      d  = m_pin ^ nv;
      nl = nv ^ INV;
      m_stat |= (m_esel & d & nl) | (~m_esel & d & ~nl);
      m_pin = nv;
   endtask

   task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output int lat, output logic rdy_after);
      iomem_valid = 1'b1;
      iomem_addr  = a;
      iomem_wdata = wd;
      iomem_wstrb = st;
      lat = 0;
      rd  = 32'h0;
      for (int i = 1; i <= 4; i++) begin
         cyc(1);
         if (iomem_ready) begin
            lat = i;
            rd  = iomem_rdata;
            break;
         end
      end
      if (lat == 0) rd = iomem_rdata;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      cyc(1);
      rdy_after = iomem_ready;
   endtask

   task automatic wr(input bit [7:0] off, input bit [31:0] wd);
      logic [31:0] rd;
      int lat;
      logic ra;
      bus({24'h030000, off}, wd, 4'hF, rd, lat, ra);
      m_write(off, wd, 4'hF);
   endtask

   task automatic rdchk(input string name, input bit [7:0] off);
      logic [31:0] rd;
      int lat;
      logic ra;
      bus({24'h030000, off}, 32'h0, 4'h0, rd, lat, ra);
      chk(name, rd, m_read(off));
   endtask

   task automatic pin(input bit [7:0] nv);
      gpio_in = nv;
      m_change(nv);
      cyc(SETTLE);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rd;
      bit          exp_rdy;
      bit          chk_rd;
   } vec_t;

   vec_t tbl[18];
   bit [7:0] offs[8];

   initial begin
      logic [31:0] rd;
      int lat;
      logic ra;
      int r;
      bit [7:0] o;
      bit [31:0] wd;
      bit [3:0] st;

      tbl[0]  = '{32'h0300_0000, 32'h0000_0000, 4'h0, 32'h00, 1'b1, 1'b1};
      tbl[1]  = '{32'h0300_0008, 32'h0000_0000, 4'h0, 32'h00, 1'b1, 1'b1};
      tbl[2]  = '{32'h0300_0010, 32'h0000_0000, 4'h0, 32'h00, 1'b1, 1'b1};
      tbl[3]  = '{32'h0300_0008, 32'h0000_000F, 4'hF, 32'h00, 1'b1, 1'b0};
      tbl[4]  = '{32'h0300_0000, 32'h1234_56A5, 4'h1, 32'h00, 1'b1, 1'b0};
      tbl[5]  = '{32'h0300_0000, 32'hFFFF_FFFF, 4'h0, 32'hA5, 1'b1, 1'b1};
      tbl[6]  = '{32'h0300_0008, 32'h0000_0000, 4'h0, 32'h0F, 1'b1, 1'b1};
      tbl[7]  = '{32'h0300_0000, 32'h0000_3C00, 4'h2, 32'h00, 1'b1, 1'b0};
      tbl[8]  = '{32'h0300_0000, 32'h0000_0000, 4'h0, 32'hA5, 1'b1, 1'b1};
      tbl[9]  = '{32'h0300_000C, 32'hFFFF_FF3C, 4'hF, 32'h00, 1'b1, 1'b0};
      tbl[10] = '{32'h0300_000C, 32'h0000_0000, 4'h0, 32'h3C, 1'b1, 1'b1};
      tbl[11] = '{32'h0300_0004, 32'h0000_0055, 4'hF, 32'h00, 1'b1, 1'b0};
      tbl[12] = '{32'h0300_0004, 32'h0000_0000, 4'h0, 32'h0F, 1'b1, 1'b1};
      tbl[13] = '{32'h0300_0020, 32'h0000_0000, 4'h0, 32'h00, 1'b1, 1'b1};
      tbl[14] = '{32'h0300_0020, 32'hFFFF_FFFF, 4'hF, 32'h00, 1'b1, 1'b0};
      tbl[15] = '{32'h0400_0000, 32'h0000_0000, 4'h0, 32'h00, 1'b0, 1'b1};
      tbl[16] = '{32'h0300_0014, 32'h0000_0000, 4'h0, 32'h00, 1'b1, 1'b1};
      tbl[17] = '{32'h0300_0001, 32'h0000_0000, 4'h0, 32'h00, 1'b1, 1'b1};
      offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20};

      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      iomem_addr  = 32'h0;
      iomem_wdata = 32'h0;
      gpio_in     = 8'h00;
      resetn      = 1'b0;
      {m_out, m_dir, m_mask, m_stat, m_esel, m_pin} = '0;
      cyc(3);
      chk("rst_ready", {31'h0, iomem_ready}, 32'h0);
      chk("rst_rdata", iomem_rdata, 32'h0);
      chk("rst_out", {24'h0, gpio_out}, 32'h0);
      chk("rst_oe", {24'h0, gpio_oe}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      resetn = 1'b1;
      cyc(SETTLE);

      for (int i = 0; i < 18; i++) begin
         bus(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, rd, lat, ra);
         chk($sformatf("tbl%0d_ready", i), {31'h0, lat != 0}, {31'h0, tbl[i].exp_rdy});
         if (tbl[i].exp_rdy) begin
            chk($sformatf("tbl%0d_latency", i), lat, 1);
            chk($sformatf("tbl%0d_ready_drop", i), {31'h0, ra}, 32'h0);
            if (tbl[i].wstrb != 4'h0) m_write(tbl[i].addr[7:0], tbl[i].wdata, tbl[i].wstrb);
         end
         if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      end
      chk("tbl_gpio_oe", {24'h0, gpio_oe}, 32'h0F);
      chk("tbl_gpio_out", {24'h0, gpio_out}, 32'hA5);
      chk("tbl_irq", {31'h0, irq}, 32'h0);

      // Valid held through the ready cycle: one idle cycle, then a second acceptance.
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0300_0000;
      iomem_wstrb = 4'h0;
      cyc(1);
      chk("hold_ready1", {31'h0, iomem_ready}, 32'h1);
      cyc(1);
      chk("hold_gap", {31'h0, iomem_ready}, 32'h0);
      chk("hold_gap_rdata", iomem_rdata, 32'h0);
      cyc(1);
      chk("hold_ready2", {31'h0, iomem_ready}, 32'h1);
      iomem_valid = 1'b0;
      cyc(2);

      // Edge detection, irq, W1C.
      wr(8'h14, 32'h01);
      wr(8'h0C, 32'h01);
      pin(8'h01);
      rdchk("edge_fall_ignored", 8'h10);
      chk("edge_irq0", {31'h0, irq}, 32'h0);
      pin(8'h00);
      rdchk("edge_rise_set", 8'h10);
      chk("edge_irq1", {31'h0, irq}, {31'h0, |(m_stat & m_mask)});
      chk("edge_stat_const", {24'h0, m_stat}, 32'h01);
      wr(8'h10, 32'h01);
      chk("w1c_irq", {31'h0, irq}, 32'h0);
      rdchk("w1c_stat", 8'h10);
`ifndef GPIO_DEBOUNCE_EN
      // Edge arrives on the same clock as the W1C write: status must keep the bit.
      pin(8'h01);
      gpio_in = 8'h00;
      cyc(2);
      bus(32'h0300_0010, 32'h01, 4'hF, rd, lat, ra);
      m_change(8'h00);
      chk("collide_latency", lat, 1);
      rdchk("collide_stat", 8'h10);
      chk("collide_irq", {31'h0, irq}, 32'h1);
      wr(8'h10, 32'hFF);
`endif

      // Randomized traffic.
      for (int it = 0; it < 60; it++) begin
         r = $urandom_range(0, 9);
         o = offs[$urandom_range(0, 7)];
         if (r < 2) begin
            pin(8'($urandom));
         end else if (r < 6) begin
            wd = $urandom;
            st = 4'($urandom_range(0, 15));
            bus({24'h030000, o}, wd, st, rd, lat, ra);
            if (st != 4'h0) m_write(o, wd, st);
         end else begin
            rdchk($sformatf("rnd%0d_rd%02h", it, o), o);
         end
         chk($sformatf("rnd%0d_out", it), {24'h0, gpio_out}, {24'h0, m_out});
         chk($sformatf("rnd%0d_oe", it), {24'h0, gpio_oe}, {24'h0, m_dir});
         chk($sformatf("rnd%0d_irq", it), {31'h0, irq}, {31'h0, |(m_stat & m_mask)});
      end

      // Reset while an access is pending, then no spurious status after release.
      gpio_in = 8'hA3;
      m_pin   = 8'hA3;
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0300_0000;
      iomem_wstrb = 4'h0;
      resetn = 1'b0;
      cyc(1);
      chk("rstmid_ready_a", {31'h0, iomem_ready}, 32'h0);
      cyc(1);
      chk("rstmid_ready_b", {31'h0, iomem_ready}, 32'h0);
      iomem_valid = 1'b0;
      cyc(1);
      chk("rstmid_out", {24'h0, gpio_out}, 32'h0);
      chk("rstmid_oe", {24'h0, gpio_oe}, 32'h0);
      chk("rstmid_irq", {31'h0, irq}, 32'h0);
      chk("rstmid_rdata", iomem_rdata, 32'h0);
      {m_out, m_dir, m_mask, m_stat, m_esel} = '0;
      resetn = 1'b1;
      cyc(SETTLE + 2);
      wr(8'h0C, 32'hFF);
      rdchk("prime_stat", 8'h10);
      chk("prime_irq", {31'h0, irq}, 32'h0);
      rdchk("prime_in", 8'h04);
      rdchk("prime_out", 8'h00);

`ifdef GPIO_DEBOUNCE_EN
      gpio_in = 8'hA2;
      cyc(3);
      gpio_in = 8'hA3;
      cyc(12);
      rdchk("db_glitch", 8'h04);
      gpio_in = 8'hA2;
      m_change(8'hA2);
      cyc(10);
      rdchk("db_stable", 8'h04);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
